mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for a 4:1 datapath mux. Four requesters
//  share one downstream port. The block picks a winner and drives the 2-bit
//  select and a one-hot grant. It gates a valid/ready handshake to the
//  consumer and caps how long one requester may hold the port.
//  Sits between the requesting units and the shared mux select.
// PARAMETERS
//  DATA_W     4  width of each requester data bus and of out_data
//  MAX_BURST  8  max transfers per grant before forced re-arbitration (1..255)
//  CNT_W      8  width of the burst counter; must satisfy 2**CNT_W > MAX_BURST
// PORTS
//  clk        in   1       single clock; all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  req        in   4       req[i]=1: requester i wants the port; held while data pending
//  in0..in3   in   DATA_W  requester data; stable while req[i]&gnt[i]&!out_ready
//  out_ready  in   1       consumer accepts out_data this cycle
//  gnt        out  4       one-hot grant (all zero when idle), registered
//  sel        out  2       mux select = index of granted requester, registered
//  out_valid  out  1       = busy & req[sel]; combinational from registered state
//  out_data   out  DATA_W  in[sel], combinational; valid only when out_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, out_valid=0.
//   Takes effect immediately, including mid-burst. The in-flight beat is dropped.
//  States: IDLE, BUSY.
//  Pick function: first i with req[i]=1 scanning ptr, ptr+1, .. mod 4.
//  IDLE: if |req, load gnt/sel with pick, cnt=0, go BUSY. Else stay IDLE.
//   Latency: req rises before edge N -> gnt/sel valid after edge N (1 cycle).
//  BUSY: transfer = out_valid & out_ready. On transfer, cnt<=cnt+1.
//   Release when either holds:
//   - req[sel]=0, no transfer that cycle. Legal early withdrawal; nothing is lost.
//   - A transfer occurs with cnt==MAX_BURST-1. The burst limit is reached.
//   On release: ptr<=sel+1 (mod 4), cnt<=0.
//    If any req remains, the pick (using the new ptr) is granted on the same edge.
//    There is no idle bubble. The releasing requester is eligible last.
//    A lone requester that hits the limit is re-granted with cnt=0.
//    If no req remains: gnt<=0, go IDLE.
//  Non-granted req changes never alter sel/gnt while BUSY (no preemption).
//  out_ready=0 stalls: sel, gnt, cnt hold. out_valid stays 1 while req[sel]=1.
//  Fairness: any requester holding req continuously is granted within 3 grants.
//  sel is never X. out_data with out_valid=0 is in[sel] and is don't-care.
//  gnt is always 0 or one-hot. gnt[sel]=1 whenever BUSY.
// STRUCTURE
//  Shared include (mux_defs.vh): state encodings ST_IDLE=1'b0, ST_BUSY=1'b1,
//   SEL_W=2, N_REQ=4.
//  Sub-module rr_pick4 (combinational): inputs req[3:0], ptr[1:0].
//   Outputs any and idx[1:0]. Used for both the IDLE grant and the same-edge re-grant.
//  Top holds the FSM, ptr, cnt, grant/select registers and the out_data case-mux.
// TESTING
//  1 Reset: rst_n=0 with req=4'hF -> gnt=0, sel=0, out_valid=0.
//    Release -> next edge gnt=4'b0001, sel=0.
//  2 Round robin: req=4'hF, out_ready=1, MAX_BURST=1 -> grants 0,1,2,3,0
//    on consecutive cycles. out_data matches in0..in3 each cycle.
//  3 Burst cap: req=4'b0011 steady, out_ready=1, MAX_BURST=8 -> 8 beats from 0.
//    Then 8 from 1, alternating. A lone req=4'b0100 is re-granted every 8 beats.
//  4 Stall: granted 2, out_ready=0 for 5 cycles -> sel=2, cnt unchanged,
//    out_valid=1. Beat counted only on the ready cycle.
//  5 Withdrawal: granted 1 after 3 beats, req[1] drops, req[3]=1 ->
//    next edge gnt=4'b1000, ptr=2, cnt=0. req=0 instead -> IDLE, gnt=0.
//  6 Async reset mid-burst: assert rst_n=0 between edges during a 5-beat burst
//    -> gnt=0 and out_valid=0 immediately. Arbitration restarts at requester 0.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4:1 round-robin mux arbiter.
// Pure definitions, no logic: state encoding, select/request widths, grant helpers.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef logic [N_REQ-1:0] req_t;
    typedef logic [SEL_W-1:0] sel_t;

    function automatic req_t onehot(input sel_t idx);
        return req_t'(1) << idx;
    endfunction

    function automatic sel_t next_sel(input sel_t idx);
        return idx + sel_t'(1);
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle around the shared 4:1 port; master drives requests,
// data and out_ready, slave (the arbiter) returns grant, select and the muxed beat.
interface mux4_rr_arbiter_if
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 4
) ();

    req_t              req;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in3;
    logic              out_ready;
    req_t              gnt;
    sel_t              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output req, in0, in1, in2, in3, out_ready,
        input  gnt, sel, out_valid, out_data
    );

    modport slave (
        input  req, in0, in1, in2, in3, out_ready,
        output gnt, sel, out_valid, out_data
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Round-robin pick: first asserted request scanning ptr, ptr+1, .. mod 4.
// Purely combinational, zero latency; no handshake of its own.
module mux4_rr_arbiter_rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  req_t req_i,
    input  sel_t ptr_i,
    output logic any_o,
    output sel_t idx_o
);

    sel_t cand;

    // Scan from the farthest offset back to ptr so the nearest request wins last.
    always_comb begin
        any_o = |req_i;
        idx_o = ptr_i;
        cand  = ptr_i;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + sel_t'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 4:1 mux with a per-grant burst cap; grant 1 cycle after req.
// Consumer backpressure (out_ready=0) freezes select, grant and beat count; no preemption.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_arbiter_if.slave bus
);

    state_e            state_q;
    req_t              gnt_q;
    sel_t              sel_q;
    sel_t              ptr_q;
    sel_t              ptr_d;
    logic [CNT_W-1:0]  cnt_q;

    logic              busy;
    logic              out_valid;
    logic              xfer;
    logic              last_beat;
    logic              rel_now;
    logic              pick_any;
    sel_t              pick_idx;
    logic [DATA_W-1:0] data_mux;

    assign busy      = (state_q == ST_BUSY);
    assign out_valid = busy & bus.req[sel_q];
    assign xfer      = out_valid & bus.out_ready;
    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign rel_now   = busy & ((xfer & last_beat) | ~bus.req[sel_q]);

    // While busy the pick is only consumed on release, where the releasing
    // requester must become the lowest priority.
    assign ptr_d = busy ? next_sel(sel_q) : ptr_q;

    mux4_rr_arbiter_rr_pick4 u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_d),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q <= ST_BUSY;
                        sel_q   <= pick_idx;
                        gnt_q   <= onehot(pick_idx);
                        cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (rel_now) begin
                        ptr_q <= ptr_d;
                        cnt_q <= '0;
                        if (pick_any) begin
                            sel_q <= pick_idx;
                            gnt_q <= onehot(pick_idx);
                        end else begin
                            state_q <= ST_IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (xfer) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        data_mux = bus.in0;
        case (sel_q)
            2'd1:    data_mux = bus.in1;
            2'd2:    data_mux = bus.in2;
            2'd3:    data_mux = bus.in3;
            default: data_mux = bus.in0;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_mux;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: two instances (burst cap 1 and 8) share stimulus,
// a per-cycle reference model checks both, literal checks pin the key scenarios.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] din [4];

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter_if #(.DATA_W(4)) if1 ();
    mux4_rr_arbiter_if #(.DATA_W(4)) if8 ();

    assign if1.req       = req;
    assign if1.in0       = din[0];
    assign if1.in1       = din[1];
    assign if1.in2       = din[2];
    assign if1.in3       = din[3];
    assign if1.out_ready = rdy;
    assign if8.req       = req;
    assign if8.in0       = din[0];
    assign if8.in1       = din[1];
    assign if8.in2       = din[2];
    assign if8.in3       = din[3];
    assign if8.out_ready = rdy;

    mux4_rr_arbiter #(.DATA_W(4), .MAX_BURST(1), .CNT_W(8)) u_b1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    mux4_rr_arbiter #(.DATA_W(4), .MAX_BURST(8), .CNT_W(8)) u_b8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the port, beats delivered in this grant,
    // and where the next round-robin scan starts.
    typedef struct packed {
        bit busy;
        int owner;
        int beats;
        int nxt;
    } mstate_t;

    mstate_t m1;
    mstate_t m8;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return 0;
    endfunction

    function automatic mstate_t reset_state();
        mstate_t s;
        s.busy = 1'b0; s.owner = 0; s.beats = 0; s.nxt = 0;
        return s;
    endfunction

    function automatic mstate_t model_step(input mstate_t m, input logic [3:0] r,
                                           input logic ready, input int maxb);
        mstate_t n;
        bit      done;
        n    = m;
        done = 1'b0;
        if (!m.busy) begin
            if (r != 4'b0) begin
                n.busy  = 1'b1;
                n.owner = pick(r, m.nxt);
                n.beats = 0;
            end
        end else begin
            if (r[m.owner] && ready) begin
                n.beats = m.beats + 1;
                done    = (n.beats == maxb);
            end else if (!r[m.owner]) begin
                done = 1'b1;
            end
            if (done) begin
                n.nxt   = (m.owner + 1) % 4;
                n.beats = 0;
                if (r != 4'b0) n.owner = pick(r, n.nxt);
                else           n.busy  = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= reset_state();
            m8 <= reset_state();
        end else begin
            m1 <= model_step(m1, req, rdy, 1);
            m8 <= model_step(m8, req, rdy, 8);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic v, input logic [3:0] d, input mstate_t m);
        logic [3:0] eg;
        logic       ev;
        eg = m.busy ? (4'b0001 << m.owner) : 4'b0000;
        ev = m.busy && req[m.owner];
        chk({tag, ".gnt"}, 32'(g), 32'(eg));
        chk({tag, ".sel"}, 32'(s), 32'(m.owner));
        chk({tag, ".out_valid"}, 32'(v), 32'(ev));
        if (ev) chk({tag, ".out_data"}, 32'(d), 32'(din[m.owner]));
    endtask

    always @(negedge clk) begin
        cmp("model_b1", if1.gnt, if1.sel, if1.out_valid, if1.out_data, m1);
        cmp("model_b8", if8.gnt, if8.sel, if8.out_valid, if8.out_data, m8);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] rr_exp [4];
        rr_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst_n  = 1'b0;
        req    = 4'hF;
        rdy    = 1'b1;
        din    = '{4'h1, 4'h6, 4'hA, 4'hD};

        // Reset holds everything idle even with all requests up.
        step(2);
        chk("reset_gnt_b1", 32'(if1.gnt), 32'h0);
        chk("reset_sel_b1", 32'(if1.sel), 32'h0);
        chk("reset_valid_b1", 32'(if1.out_valid), 32'h0);
        chk("reset_gnt_b8", 32'(if8.gnt), 32'h0);
        chk("reset_sel_b8", 32'(if8.sel), 32'h0);
        chk("reset_valid_b8", 32'(if8.out_valid), 32'h0);
        rst_n = 1'b1;
        step(1);
        chk("first_gnt_b1", 32'(if1.gnt), 32'h1);
        chk("first_sel_b1", 32'(if1.sel), 32'h0);
        chk("first_gnt_b8", 32'(if8.gnt), 32'h1);

        // Burst of one: grants rotate every cycle.
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("rr_sel_b1", 32'(if1.sel), 32'(rr_exp[k]));
            chk("rr_gnt_b1", 32'(if1.gnt), 32'(4'b0001 << rr_exp[k]));
            chk("rr_data_b1", 32'(if1.out_data), 32'(din[rr_exp[k]]));
        end
        chk("rr_hold_b8", 32'(if8.sel), 32'h0);

        // Burst cap of 8 alternating between requesters 0 and 1.
        din = '{4'h3, 4'hC, 4'h5, 4'h9};
        req = 4'b0011;
        do_reset();
        step(1);
        for (int k = 0; k < 24; k++) begin
            chk("burst_sel_b8", 32'(if8.sel), 32'((k / 8) % 2));
            step(1);
        end

        // Lone requester is re-granted; a newcomer waits for the cap.
        req = 4'b0100;
        do_reset();
        step(1);
        for (int k = 0; k < 20; k++) begin
            chk("lone_gnt_b8", 32'(if8.gnt), 32'h4);
            chk("lone_valid_b8", 32'(if8.out_valid), 32'h1);
            step(1);
        end
        req = 4'b1100;
        step(3);
        chk("lone_tail_sel_b8", 32'(if8.sel), 32'h2);
        step(1);
        chk("lone_handoff_sel_b8", 32'(if8.sel), 32'h3);

        // Stall: no beats counted while out_ready is low.
        req = 4'b0100;
        rdy = 1'b0;
        do_reset();
        step(1);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("stall_sel_b8", 32'(if8.sel), 32'h2);
            chk("stall_valid_b8", 32'(if8.out_valid), 32'h1);
        end
        rdy = 1'b1;
        req = 4'b1100;
        step(7);
        chk("stall_keep_sel_b8", 32'(if8.sel), 32'h2);
        step(1);
        chk("stall_release_sel_b8", 32'(if8.sel), 32'h3);

        // Withdrawal hands over on the same edge.
        req = 4'b0010;
        do_reset();
        step(4);
        chk("wd_sel_b8", 32'(if8.sel), 32'h1);
        req = 4'b1000;
        #1 chk("wd_valid_drop_b8", 32'(if8.out_valid), 32'h0);
        step(1);
        chk("wd_gnt_b8", 32'(if8.gnt), 32'h8);
        chk("wd_sel3_b8", 32'(if8.sel), 32'h3);

        // Withdrawal to idle, then the pointer sits just past requester 1.
        req = 4'b0010;
        do_reset();
        step(4);
        req = 4'b0000;
        step(1);
        chk("idle_gnt_b8", 32'(if8.gnt), 32'h0);
        chk("idle_valid_b8", 32'(if8.out_valid), 32'h0);
        req = 4'b0111;
        step(1);
        chk("ptr_sel_b8", 32'(if8.sel), 32'h2);
        chk("ptr_gnt_b8", 32'(if8.gnt), 32'h4);

        // Asynchronous reset in the middle of a burst.
        req = 4'b0011;
        do_reset();
        step(4);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_gnt_b8", 32'(if8.gnt), 32'h0);
        chk("areset_valid_b8", 32'(if8.out_valid), 32'h0);
        chk("areset_sel_b8", 32'(if8.sel), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);
        chk("restart_gnt_b8", 32'(if8.gnt), 32'h1);
        chk("restart_sel_b8", 32'(if8.sel), 32'h0);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
